equiv_check_sequencer: RTL and testbench
========================================

EQUIV_CHECK_SEQUENCER -- requirements
Module: equiv_check_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the stimulus bus and both compared output buses.
REQ-002 SHALL have parameter NUM_VECTORS, default 1000: number of vectors per run; legal range 1..65535.
REQ-003 SHALL have parameter RST_CYCLES, default 2: number of cycles dut_rst is held high at run start; minimum 1.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2: number of cycles from stimulus update to compare; minimum 1.
REQ-005 SHALL have parameter SEED, default 32'h1: LFSR seed; a value of 0 SHALL be replaced by 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request that begins a run.
REQ-009 SHALL have port abort, input, 1 bit: terminates the current run.
REQ-010 SHALL have port golden_out, input, WIDTH bits: output of the reference model.
REQ-011 SHALL have port netlist_out, input, WIDTH bits: output of the post-route netlist.
REQ-012 SHALL have port dut_rst, output, 1 bit: reset driven to both DUT copies.
REQ-013 SHALL have port stim, output, WIDTH bits: stimulus driven to both DUT copies.
REQ-014 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-015 SHALL have port done, output, 1 bit: high when a run has completed.
REQ-016 SHALL have port pass, output, 1 bit: run verdict.
REQ-017 SHALL have port vec_cnt, output, 16 bits: number of vectors compared in the current run.
REQ-018 SHALL have port mismatch_cnt, output, 16 bits: number of mismatching vectors in the current run.

Function
REQ-019 SHALL implement states IDLE, DUTRST, SETTLE, DRIVE, WAIT, COMPARE, DONE.
REQ-020 IDLE or DONE with start=1: SHALL go to DUTRST, clear vec_cnt and mismatch_cnt, reload the LFSR with SEED, drive stim=0, clear done and pass.
REQ-021 DUTRST: SHALL drive dut_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE.
REQ-022 SETTLE: SHALL hold dut_rst=0 and stim=0 for exactly 1 cycle, then go to DRIVE.
REQ-023 DRIVE: SHALL register stim<=lfsr, advance the LFSR once (Galois, taps 32'h80200003, truncated/zero-extended to WIDTH), and go to WAIT.
REQ-024 WAIT: SHALL last exactly WAIT_CYCLES cycles, then go to COMPARE.
REQ-025 COMPARE: SHALL increment vec_cnt, and increment mismatch_cnt if golden_out != netlist_out; mismatch_cnt SHALL saturate at 16'hFFFF.
REQ-026 COMPARE: SHALL go to DONE when the incremented vec_cnt equals NUM_VECTORS, else to DRIVE; vector period SHALL be WAIT_CYCLES+2 cycles.
REQ-027 DONE: SHALL hold done=1 and pass=(mismatch_cnt==0); done SHALL stay high until the next start.
REQ-028 busy SHALL be 1 in every state except IDLE and DONE; start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any busy state SHALL go to IDLE next cycle with dut_rst=0 and done=0, counters retained.
REQ-030 abort and start in the same cycle while IDLE or DONE: abort SHALL win, with no run started.
REQ-031 stim SHALL change only in DRIVE, on entry to DUTRST, and on reset.

Reset
REQ-032 rst=1 SHALL force IDLE, stim=0, dut_rst=1, busy=0, done=0, pass=0, vec_cnt=0, mismatch_cnt=0, LFSR=SEED, asynchronously.
REQ-033 After rst deasserts, dut_rst SHALL drop to 0 on the first clock edge in IDLE.
REQ-034 rst mid-run SHALL discard the run, and a new start SHALL be required.

Configuration
REQ-035 With macro EQUIV_FIRST_FAIL_CAPTURE_EN defined, SHALL add outputs fail_valid (1 bit), fail_index (16 bits), fail_golden (WIDTH bits) and fail_netlist (WIDTH bits).
REQ-036 With the macro defined, these outputs SHALL latch on the first mismatching COMPARE of a run, hold until the next start or rst, and reset to 0.
REQ-037 Without the macro, those ports and registers SHALL be absent and behaviour otherwise identical.

Structure
REQ-038 Package equiv_check_pkg SHALL hold the state enum, LFSR tap constant 32'h80200003, and the 16-bit counter width constant.
REQ-039 The LFSR SHALL be sub-module equiv_lfsr, with ports clk, rst, load, seed, advance and value.

Verification
REQ-040 rst, then start, with golden_out==netlist_out tied: SHALL give dut_rst high 2 cycles, done after 2+1+1000*4 cycles, pass=1, vec_cnt=1000, mismatch_cnt=0.
REQ-041 NUM_VECTORS=8, netlist_out=golden_out^1 on vectors 3 and 6: SHALL give mismatch_cnt=2 and pass=0; with the macro, fail_index=3.
REQ-042 SEED=0: SHALL give first stim=32'h1 and second stim=32'h80200003.
REQ-043 abort asserted on vector 5: SHALL return to IDLE next cycle with busy=0, done=0, vec_cnt=4 (or 5 if asserted in COMPARE).
REQ-044 start pulsed during WAIT: SHALL be ignored, with vec_cnt sequence unchanged.
REQ-045 rst pulsed during WAIT: SHALL immediately give stim=0, busy=0, counters 0; then start SHALL rerun cleanly.

Source files
------------

// File: rtl/equiv_check_pkg.sv
// Shared types and constants for the equivalence-check sequencer and its LFSR.
package equiv_check_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [2:0] {
    IDLE,
    DUTRST,
    SETTLE,
    DRIVE,
    WAIT,
    COMPARE,
    DONE
  } state_e;

endpackage

// File: rtl/equiv_lfsr.sv
// Galois LFSR producing the stimulus word; load restarts from seed, advance steps once.
module equiv_lfsr
  import equiv_check_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = value_q[0] ? ((value_q >> 1) ^ TAPS) : (value_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/equiv_check_sequencer.sv
// Drives LFSR stimulus into a golden model and a netlist, compares their outputs per vector.
// Optional first-mismatch capture outputs are enabled by defining EQUIV_FIRST_FAIL_CAPTURE_EN.
module equiv_check_sequencer
  import equiv_check_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_VECTORS = 1000,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  golden_out,
  input  logic [WIDTH-1:0]  netlist_out,
  output logic              dut_rst,
  output logic [WIDTH-1:0]  stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
  ,
  output logic              fail_valid,
  output logic [CNT_W-1:0]  fail_index,
  output logic [WIDTH-1:0]  fail_golden,
  output logic [WIDTH-1:0]  fail_netlist
`endif
);

  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic               dut_rst_q, dut_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0]   vec_inc_c;
  logic               mismatch_c;
  logic               lfsr_load_c;
  logic               lfsr_adv_c;
  logic [WIDTH-1:0]   lfsr_value;
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
  logic               fail_valid_q, fail_valid_d;
  logic [CNT_W-1:0]   fail_index_q, fail_index_d;
  logic [WIDTH-1:0]   fail_golden_q, fail_golden_d;
  logic [WIDTH-1:0]   fail_netlist_q, fail_netlist_d;
`endif

  equiv_lfsr #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load_c),
    .seed    (SEED_EFF),
    .advance (lfsr_adv_c),
    .value   (lfsr_value)
  );

  // Next-state and registered-output logic; abort overrides whatever the state decided.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stim_d      = stim_q;
    dut_rst_d   = dut_rst_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    vec_cnt_d   = vec_cnt_q;
    mm_cnt_d    = mm_cnt_q;
    lfsr_load_c = 1'b0;
    lfsr_adv_c  = 1'b0;
    vec_inc_c   = vec_cnt_q + CNT_W'(1);
    mismatch_c  = (golden_out != netlist_out);
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
    fail_valid_d   = fail_valid_q;
    fail_index_d   = fail_index_q;
    fail_golden_d  = fail_golden_q;
    fail_netlist_d = fail_netlist_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        dut_rst_d = 1'b0;
        if (start && !abort) begin
          state_d     = DUTRST;
          timer_d     = TMR_W'(RST_CYCLES - 1);
          stim_d      = '0;
          dut_rst_d   = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          vec_cnt_d   = '0;
          mm_cnt_d    = '0;
          lfsr_load_c = 1'b1;
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
          fail_valid_d   = 1'b0;
          fail_index_d   = '0;
          fail_golden_d  = '0;
          fail_netlist_d = '0;
`endif
        end
      end
      DUTRST: begin
        if (timer_q == '0) begin
          state_d   = SETTLE;
          dut_rst_d = 1'b0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      SETTLE: begin
        state_d = DRIVE;
      end
      DRIVE: begin
        stim_d     = lfsr_value;
        lfsr_adv_c = 1'b1;
        timer_d    = TMR_W'(WAIT_CYCLES - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (timer_q == '0) begin
          state_d = COMPARE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      COMPARE: begin
        vec_cnt_d = vec_inc_c;
        if (mismatch_c && (mm_cnt_q != '1)) begin
          mm_cnt_d = mm_cnt_q + CNT_W'(1);
        end
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
        if (mismatch_c && !fail_valid_q) begin
          fail_valid_d   = 1'b1;
          fail_index_d   = vec_inc_c;
          fail_golden_d  = golden_out;
          fail_netlist_d = netlist_out;
        end
`endif
        if (vec_inc_c == CNT_W'(NUM_VECTORS)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mm_cnt_d == '0);
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      dut_rst_d = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      stim_q    <= '0;
      dut_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vec_cnt_q <= '0;
      mm_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stim_q    <= stim_d;
      dut_rst_q <= dut_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      vec_cnt_q <= vec_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
    end
  end

`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
  // First mismatch of a run, held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid_q   <= 1'b0;
      fail_index_q   <= '0;
      fail_golden_q  <= '0;
      fail_netlist_q <= '0;
    end else begin
      fail_valid_q   <= fail_valid_d;
      fail_index_q   <= fail_index_d;
      fail_golden_q  <= fail_golden_d;
      fail_netlist_q <= fail_netlist_d;
    end
  end

  assign fail_valid   = fail_valid_q;
  assign fail_index   = fail_index_q;
  assign fail_golden  = fail_golden_q;
  assign fail_netlist = fail_netlist_q;
`endif

  assign dut_rst      = dut_rst_q;
  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign vec_cnt      = vec_cnt_q;
  assign mismatch_cnt = mm_cnt_q;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Scoreboard bench: expected stimulus words and run results are queued, a monitor checks them.
module tb_equiv_check_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NV    = 8;
  // Edges from the start-sampling edge to done: RST_CYCLES + SETTLE + NV*(WAIT_CYCLES+2).
  localparam int          DONE_EDGES = 2 + 1 + 8 * 4;

  typedef struct packed {
    logic [15:0] vec;
    logic [15:0] mm;
    logic        pass;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  golden_out;
  logic [WIDTH-1:0]  netlist_out;
  logic              dut_rst;
  logic [WIDTH-1:0]  stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       vec_cnt;
  logic [15:0]       mismatch_cnt;
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
  logic              fail_valid;
  logic [15:0]       fail_index;
  logic [WIDTH-1:0]  fail_golden;
  logic [WIDTH-1:0]  fail_netlist;
`endif

  logic [15:0] bad_mask;
  int          vidx;
  logic        inj;
  int          total;
  int          bad;
  res_t        exp_res_q[$];
  logic [31:0] exp_stim_q[$];

  // Hand-computed Galois sequence from seed 0 (replaced by 1), taps 32'h80200003.
  logic [31:0] stim_tab [8] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
                                32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003};

  always #5 clk = ~clk;

  assign golden_out  = stim;
  assign inj         = (vidx >= 0) && (vidx < 16) && bad_mask[vidx[3:0]];
  assign netlist_out = stim ^ {31'b0, inj};

  equiv_check_sequencer #(
    .WIDTH       (WIDTH),
    .NUM_VECTORS (NV),
    .RST_CYCLES  (2),
    .WAIT_CYCLES (2),
    .SEED        (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .golden_out   (golden_out),
    .netlist_out  (netlist_out),
    .dut_rst      (dut_rst),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .vec_cnt      (vec_cnt),
    .mismatch_cnt (mismatch_cnt)
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
    ,
    .fail_valid   (fail_valid),
    .fail_index   (fail_index),
    .fail_golden  (fail_golden),
    .fail_netlist (fail_netlist)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic push_run(input int nstim, input logic [15:0] vec, input logic [15:0] mm,
                          input logic ps, input bit with_res);
    res_t r;
    for (int i = 0; i < nstim; i++) exp_stim_q.push_back(stim_tab[i]);
    r.vec  = vec;
    r.mm   = mm;
    r.pass = ps;
    if (with_res) exp_res_q.push_back(r);
  endtask

  task automatic monitor();
    logic [31:0] prev_stim;
    logic        prev_done;
    res_t        got;
    prev_stim = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) vidx = 0;
      if ((stim !== prev_stim) && (stim != '0)) begin
        vidx++;
        if (exp_stim_q.size() == 0) check("stim_unexpected", 64'(stim), 64'd0);
        else check("stim_value", 64'(stim), 64'(exp_stim_q.pop_front()));
      end
      if (done && !prev_done) begin
        got.vec  = vec_cnt;
        got.mm   = mismatch_cnt;
        got.pass = pass;
        if (exp_res_q.size() == 0) check("done_unexpected", 64'(got), 64'd0);
        else check("run_result", 64'(got), 64'(exp_res_q.pop_front()));
      end
      prev_stim = stim;
      prev_done = done;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_vidx(input int n);
    int k;
    k = 0;
    while ((vidx < n) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    check("reach_vector", 64'(vidx >= n), 64'd1);
  endtask

  // Full run from start to done; optionally pulses a stray start mid-run.
  task automatic run_timed(input int stray_at);
    int cyc;
    int rst_hi;
    cyc    = 0;
    rst_hi = 0;
    @(negedge clk) start = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == stray_at);
      if (dut_rst) rst_hi++;
    end while (!done && (cyc < 500));
    start = 1'b0;
    check("done_latency", 64'(cyc), 64'(DONE_EDGES + 1));
    check("dut_rst_cycles", 64'(rst_hi), 64'd2);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic main_seq();
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    bad_mask = '0;
    #12;
    check("rst_stim", 64'(stim), 64'd0);
    check("rst_dut_rst", 64'(dut_rst), 64'd1);
    check("rst_flags", 64'({busy, done, pass}), 64'd0);
    check("rst_counts", 64'({vec_cnt, mismatch_cnt}), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("dut_rst_release", 64'(dut_rst), 64'd0);

    // Clean run with a stray start during WAIT.
    push_run(8, 16'd8, 16'd0, 1'b1, 1'b1);
    run_timed(9);

    // Mismatches on vectors 3 and 6.
    bad_mask = 16'h0048;
    push_run(8, 16'd8, 16'd2, 1'b0, 1'b1);
    run_timed(0);
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
    check("fail_valid", 64'(fail_valid), 64'd1);
    check("fail_index", 64'(fail_index), 64'd3);
    check("fail_golden", 64'(fail_golden), 64'h00000000C0300002);
    check("fail_netlist", 64'(fail_netlist), 64'h00000000C0300003);
`else
    $display("first-fail capture disabled in this build");
`endif

    // Abort during vector 5.
    bad_mask = '0;
    push_run(5, 16'd0, 16'd0, 1'b0, 1'b0);
    pulse_start();
    wait_vidx(5);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy_done", 64'({busy, done, dut_rst}), 64'd0);
    check("abort_vec_cnt", 64'(vec_cnt), 64'd4);
    check("abort_mm_cnt", 64'(mismatch_cnt), 64'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wins_busy", 64'({busy, dut_rst}), 64'd0);
    check("abort_wins_vec", 64'(vec_cnt), 64'd4);

    // Reset during WAIT of vector 2.
    push_run(2, 16'd0, 16'd0, 1'b0, 1'b0);
    pulse_start();
    wait_vidx(2);
    #2 rst = 1'b1;
    #1;
    check("midrst_stim", 64'(stim), 64'd0);
    check("midrst_flags", 64'({busy, done, dut_rst}), 64'd1);
    check("midrst_counts", 64'({vec_cnt, mismatch_cnt}), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_idle", 64'({busy, dut_rst}), 64'd0);

    // Clean rerun, mismatch on the final vector only.
    bad_mask = 16'h0100;
    push_run(8, 16'd8, 16'd1, 1'b0, 1'b1);
    run_timed(0);
`ifdef EQUIV_FIRST_FAIL_CAPTURE_EN
    check("fail_index_last", 64'(fail_index), 64'd8);
`endif
    repeat (3) @(negedge clk);
    check("stim_queue_empty", 64'(exp_stim_q.size()), 64'd0);
    check("res_queue_empty", 64'(exp_res_q.size()), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vidx  = 0;
    fork
      monitor();
      main_seq();
      begin
        #200000;
        bad++;
        $display("FAIL global_timeout: got timeout, want completion");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
